// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: in RUN, pulses tick and toggles sclk every div_reg+1 cycles.
// New divide values are taken directly in IDLE and deferred to the next half-period boundary in RUN.
module clk_div_ctrl #(
  parameter int          WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 200000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             busy,
  output logic             tick,
  output logic             sclk,
  output logic [15:0]      tick_count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] div_cnt;
  logic [WIDTH-1:0] pending_div;
  logic             pending;
  logic             xfer;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // stop always wins over start, so IDLE only leaves on a clean start
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !stop) state_next = RUN;
      RUN:     if (stop)           state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == RUN);
  assign tick      = busy && (div_cnt == div_reg);
  assign cfg_ready = !pending;
  assign xfer      = cfg_valid && !pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg     <= WIDTH'(DEFAULT_DIV);
      div_cnt     <= '0;
      sclk        <= 1'b0;
      pending     <= 1'b0;
      pending_div <= '0;
      tick_count  <= '0;
    end else begin
      if (tick) tick_count <= tick_count + 16'd1;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (xfer) div_reg <= cfg_div;
        end
        RUN: begin
          if (stop) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            // a value accepted on the stop cycle is applied directly so it never strands in pending
            if (pending) begin
              div_reg <= pending_div;
              pending <= 1'b0;
            end else if (xfer) begin
              div_reg <= cfg_div;
            end
          end else begin
            if (tick) begin
              div_cnt <= '0;
              sclk    <= ~sclk;
              if (pending) begin
                div_reg <= pending_div;
                pending <= 1'b0;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
            if (xfer) begin
              pending_div <= cfg_div;
              pending     <= 1'b1;
            end
          end
        end
        default: div_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: vector table, directed multi-cycle sequences,
// then randomized traffic against a half-period reference model.
module tb_clk_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, cfgValid;
  logic [31:0] cfgDiv;
  logic        cfgReady, busy, tick, sclk;
  logic [15:0] tickCount;

  int checkCount = 0;
  int passCount  = 0;

  clk_div_ctrl #(.WIDTH(32), .DEFAULT_DIV(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_valid(cfgValid), .cfg_div(cfgDiv), .cfg_ready(cfgReady),
    .busy(busy), .tick(tick), .sclk(sclk), .tick_count(tickCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, start, stop, cfgValid;
    logic [31:0] cfgDiv;
    logic        expBusy, expTick, expSclk, expReady;
    logic [15:0] expCount;
  } vec_t;

  vec_t vecs[$];

  // reference model: tracks position inside the current half-period
  logic        mRun, mSclk, mPend;
  logic [15:0] mCount;
  logic [31:0] mDiv, mPendDiv;
  longint      mElapsed;

  function automatic vec_t mk(logic r, logic s, logic p, logic v, logic [31:0] d,
                              logic eb, logic et, logic es, logic er, logic [15:0] ec);
    vec_t x;
    x.rst = r; x.start = s; x.stop = p; x.cfgValid = v; x.cfgDiv = d;
    x.expBusy = eb; x.expTick = et; x.expSclk = es; x.expReady = er; x.expCount = ec;
    return x;
  endfunction

  task automatic setInputs(input logic r, input logic s, input logic p, input logic v,
                           input logic [31:0] d);
    rst = r; start = s; stop = p; cfgValid = v; cfgDiv = d;
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic p, input logic v,
                               input logic [31:0] d);
    setInputs(r, s, p, v, d);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // steps with the current inputs until tick is seen; n = cycles stepped, -1 on timeout
  task automatic waitTick(output int n);
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      if (tick) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic logic modelTick();
    longint halfLen;
    halfLen = longint'(mDiv) + 1;
    return mRun && (mElapsed + 1 == halfLen);
  endfunction

  task automatic modelStep(input logic r, input logic s, input logic p, input logic v,
                           input logic [31:0] d);
    logic t, accept;
    t      = modelTick();
    accept = v && !mPend;
    if (r) begin
      mRun = 0; mSclk = 0; mPend = 0; mCount = 0; mDiv = 3; mPendDiv = 0; mElapsed = 0;
    end else begin
      if (t) mCount = mCount + 16'd1;
      if (!mRun) begin
        if (accept) mDiv = d;
        if (s && !p) begin
          mRun = 1;
          mElapsed = 0;
        end
      end else if (p) begin
        mRun = 0; mSclk = 0; mElapsed = 0;
        if (mPend) begin
          mDiv = mPendDiv;
          mPend = 0;
        end else if (accept) begin
          mDiv = d;
        end
      end else begin
        if (t) begin
          mSclk = ~mSclk;
          mElapsed = 0;
          if (mPend) begin
            mDiv = mPendDiv;
            mPend = 0;
          end
        end else begin
          mElapsed++;
        end
        if (accept) begin
          mPend = 1;
          mPendDiv = d;
        end
      end
    end
  endtask

  initial begin
    int n;
    setInputs(0, 0, 0, 0, 0);

    // basic run, start ignored in RUN, stop, start+stop contention, config in IDLE with div 0
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,1,0));
    vecs.push_back(mk(0,1,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,1,1));
    vecs.push_back(mk(0,1,0,0,0, 1,0,1,1,1));
    vecs.push_back(mk(0,1,0,0,0, 1,0,1,1,1));
    vecs.push_back(mk(0,0,0,0,0, 1,1,1,1,1));
    vecs.push_back(mk(0,0,0,0,0, 1,0,0,1,2));
    vecs.push_back(mk(0,0,0,0,0, 1,0,0,1,2));
    vecs.push_back(mk(0,0,0,0,0, 1,0,0,1,2));
    vecs.push_back(mk(0,0,0,0,0, 1,1,0,1,2));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,1,3));
    vecs.push_back(mk(0,0,1,0,0, 0,0,0,1,3));
    vecs.push_back(mk(0,1,1,0,0, 0,0,0,1,3));
    vecs.push_back(mk(0,0,0,1,0, 0,0,0,1,3));
    vecs.push_back(mk(0,1,0,0,0, 1,1,0,1,3));
    vecs.push_back(mk(0,0,0,0,0, 1,1,1,1,4));
    vecs.push_back(mk(0,0,0,0,0, 1,1,0,1,5));
    vecs.push_back(mk(1,1,1,1,7, 0,0,0,1,0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].cfgValid, vecs[i].cfgDiv);
      checkOutput($sformatf("vec%0d", i), {12'd0, busy, tick, sclk, cfgReady, tickCount},
                  {12'd0, vecs[i].expBusy, vecs[i].expTick, vecs[i].expSclk,
                   vecs[i].expReady, vecs[i].expCount});
    end

    // config offered mid-RUN is deferred to the next half-period
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    setInputs(0, 0, 0, 0, 0);
    waitTick(n);                     checkOutput("first_half", n, 3);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);    checkOutput("ready_drop", cfgReady, 0);
    setInputs(0, 0, 0, 0, 0);
    waitTick(n);                     checkOutput("old_half", 3 + n, 4);
    checkOutput("ready_hold", cfgReady, 0);
    waitTick(n);                     checkOutput("new_half1", n, 2);
    checkOutput("ready_back", cfgReady, 1);
    waitTick(n);                     checkOutput("new_half2", n, 2);

    // stop while a value is pending applies it
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5);    checkOutput("pend5_ready", cfgReady, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("stop_state", {busy, sclk, cfgReady}, 3'b001);
    applyStimulus(0, 1, 0, 0, 0);
    setInputs(0, 0, 0, 0, 0);
    waitTick(n);                     checkOutput("div5_first", n + 1, 6);
    waitTick(n);                     checkOutput("div5_half", n, 6);

    // second offer while pending is refused; first value wins
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 2);    checkOutput("pend2_ready", cfgReady, 0);
    applyStimulus(0, 0, 0, 1, 4);
    setInputs(0, 0, 0, 0, 0);
    waitTick(n);                     checkOutput("div5_finish", n + 3, 6);
    waitTick(n);                     checkOutput("div2_half1", n, 3);
    waitTick(n);                     checkOutput("div2_half2", n, 3);
    checkOutput("ready_after2", cfgReady, 1);

    // reset with a pending value discards it
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 9);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_pend", {busy, tick, sclk, cfgReady, tickCount}, {4'b0001, 16'd0});
    applyStimulus(0, 1, 0, 0, 0);
    setInputs(0, 0, 0, 0, 0);
    waitTick(n);                     checkOutput("rst_default_div", n, 3);

    // tick_count wrap with div 0, then reset mid-RUN
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    setInputs(0, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("count_ffff", tickCount, 16'hFFFF);
    checkOutput("sclk_odd", sclk, 1);
    applyStimulus(0, 0, 0, 0, 0);    checkOutput("count_wrap", tickCount, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 6);
    checkOutput("rst_mid_run", {busy, tick, sclk, cfgReady, tickCount}, {4'b0001, 16'd0});

    // randomized traffic against the reference model
    modelStep(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic r, s, p, v;
      logic [31:0] d;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 5) == 0);
      d = $urandom_range(0, 5);
      applyStimulus(r, s, p, v, d);
      modelStep(r, s, p, v, d);
      checkOutput($sformatf("rand%0d", i), {12'd0, busy, tick, sclk, cfgReady, tickCount},
                  {12'd0, mRun, modelTick(), mSclk, !mPend, mCount});
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: width of the divide register and counter.
REQ-002 Parameter DEFAULT_DIV, default 200000: divide value loaded at reset.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to begin dividing; sampled each cycle.
REQ-007 stop  input  1  request to halt dividing; sampled each cycle.
REQ-008 cfg_valid  input  1  a new divide value is offered on cfg_div.
REQ-009 cfg_div  input  WIDTH  offered divide value; the half-period is cfg_div+1 cycles.
REQ-010 cfg_ready  output  1  the block can accept a cfg_div value this cycle.
REQ-011 busy  output  1  high while in RUN.
REQ-012 tick  output  1  one-cycle pulse at each half-period boundary.
REQ-013 sclk  output  1  divided clock; toggles on every tick.
REQ-014 tick_count  output  16  count of ticks since reset; wraps.

Function
REQ-015 States: IDLE and RUN; busy = (state == RUN).
REQ-016 IDLE -> RUN when start=1 and stop=0; div_cnt is loaded with 0 on this transition.
REQ-017 RUN -> IDLE when stop=1; the same cycle loads div_cnt with 0 and sclk with 0.
REQ-018 When start and stop are both high, stop wins; in IDLE the block stays in IDLE.
REQ-019 start asserted while in RUN is ignored and does not restart the counter.
REQ-020 In RUN, if div_cnt == div_reg: drive tick=1 for that cycle, toggle sclk, and load div_cnt with 0; otherwise increment div_cnt by 1.
REQ-021 Half-period = div_reg+1 cycles, full sclk period = 2*(div_reg+1) cycles.
REQ-022 div_reg = 0 is legal: tick every cycle, and sclk toggles every cycle.
REQ-023 In IDLE, div_cnt holds 0, tick = 0, and sclk holds its last value (0 after stop or reset).
REQ-024 Config handshake: a transfer occurs when cfg_valid and cfg_ready are both high on the same cycle.
REQ-025 cfg_ready = NOT pending, where pending is a single-entry holding flag.
REQ-026 A transfer in IDLE writes div_reg <= cfg_div immediately; pending stays 0.
REQ-027 A transfer in RUN stores pending_div <= cfg_div and sets pending=1; div_reg is unchanged.
REQ-028 While pending=1 in RUN, the next tick cycle writes div_reg <= pending_div and clears pending.
REQ-029 That tick completes the old half-period; the following half-period uses the new value.
REQ-030 A stop while pending=1 writes div_reg <= pending_div and clears pending in the same cycle.
REQ-031 Offers made while cfg_ready=0 are not accepted; the source must hold cfg_valid and cfg_div stable until the transfer occurs.
REQ-032 tick_count increments by 1 on each tick and wraps from 16'hFFFF to 0.
REQ-033 A new div_reg value never truncates or extends a half-period already in progress.
REQ-034 All outputs are registered except busy, cfg_ready and tick, which decode registered state only.

Reset
REQ-035 rst=1 at a rising edge forces: state=IDLE, div_reg=DEFAULT_DIV, div_cnt=0, sclk=0, pending=0, pending_div=0, tick_count=0.
REQ-036 Resulting outputs after reset: tick=0, busy=0, cfg_ready=1.
REQ-037 Reset overrides start, stop and cfg_valid in the same cycle.
REQ-038 Reset applied mid-RUN or with pending=1 discards all progress and the pending value.

Verification (DEFAULT_DIV=3)
REQ-039 Basic run: reset, then start for 1 cycle -> first tick 4 cycles after start is sampled; sclk goes 1, 0, 1 at intervals of 4 cycles; tick_count=3 after 3 ticks.
REQ-040 Config in IDLE: cfg_valid with cfg_div=0, then start -> tick every cycle and sclk toggles every cycle.
REQ-041 Config mid-RUN: in RUN with div_reg=3, offer cfg_div=1 at div_cnt=1 ->
  - cfg_ready drops the next cycle;
  - the current half-period still lasts 4 cycles;
  - later half-periods last 2 cycles;
  - cfg_ready returns to 1 after that tick.
REQ-042 Stop with pending: stop while pending=1 (pending_div=5) ->
  - IDLE next cycle, sclk=0, div_reg=5;
  - a subsequent start gives 6-cycle half-periods.
REQ-043 Contention: start and stop high together in IDLE -> stays IDLE; a second cfg_valid while pending=1 -> not accepted, first value applied.
REQ-044 Wrap and reset: preload 65535 ticks, then one more tick -> tick_count=0; assert rst mid-RUN -> all REQ-035 values on the next cycle.
